// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_pkg
//  Description : Shared state encoding, opcode constants and datapath select
//                encodings for the multicycle controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

  // FSM states; the numeric values are visible on the debug state port
  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4
  } state_t;

  // Supported opcodes (instruction[31:26])
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_addi  = 6'b001000;

  // PC source select
  localparam logic [1:0] c_pc_src_plus4  = 2'b00;
  localparam logic [1:0] c_pc_src_branch = 2'b01;
  localparam logic [1:0] c_pc_src_jump   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] c_alu_b_rt      = 2'b00;
  localparam logic [1:0] c_alu_b_four    = 2'b01;
  localparam logic [1:0] c_alu_b_imm     = 2'b10;
  localparam logic [1:0] c_alu_b_imm_sh2 = 2'b11;

  // ALU operation class
  localparam logic [1:0] c_alu_op_add   = 2'b00;
  localparam logic [1:0] c_alu_op_sub   = 2'b01;
  localparam logic [1:0] c_alu_op_funct = 2'b10;

  // True for every opcode the controller knows how to sequence
  function automatic logic is_supported(input logic [5:0] op);
    return (op == c_op_rtype) || (op == c_op_lw)  || (op == c_op_sw) ||
           (op == c_op_beq)   || (op == c_op_j)   || (op == c_op_addi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/retire_counter.sv
`default_nettype none
// ============================================================================
//  Module      : retire_counter
//  Description : Free-running retired-instruction counter with enable,
//                synchronous active-low reset and natural wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module retire_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Count one per enabled cycle; the register is rewritten every edge so a
  // held value simply re-adds zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, en};
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Five-state multicycle controller (fetch/decode/execute/
//                mem/writeback) producing datapath control strobes, plus a
//                retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dest,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  state_t      r_state;
  state_t      w_next_state;
  logic [5:0]  r_opcode;
  logic        r_active;
  logic        w_out_en;

  logic        w_pc_en;
  logic [1:0]  w_pc_src;
  logic        w_ir_write;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_reg_write;
  logic        w_reg_dest;
  logic        w_mem_to_reg;
  logic        w_alu_src_a;
  logic [1:0]  w_alu_src_b;
  logic [1:0]  w_alu_op;
  logic        w_instr_done;
  logic        w_illegal_op;

  // r_active goes high one edge after reset is released, so the first
  // fetch read lands in the cycle following the sampled deassertion and
  // all strobes stay quiet while rst_n is low
  assign w_out_en = rst_n & r_active;

  // State register, opcode latch and post-reset enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_state  <= ST_FETCH;
      r_opcode <= c_op_rtype;
    end else begin
      r_active <= 1'b1;
      if (r_active) begin
        r_state <= w_next_state;
        if (r_state == ST_DECODE) begin
          r_opcode <= opcode;
        end
      end
    end
  end

  // Next-state and raw control decode; later states use the latched opcode
  always_comb begin
    w_next_state = r_state;
    w_pc_en      = 1'b0;
    w_pc_src     = c_pc_src_plus4;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dest   = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = c_alu_b_rt;
    w_alu_op     = c_alu_op_add;
    w_instr_done = 1'b0;
    w_illegal_op = 1'b0;

    case (r_state)
      ST_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = c_alu_b_four;
        if (mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_en      = 1'b1;
          w_pc_src     = c_pc_src_plus4;
          w_next_state = ST_DECODE;
        end
      end

      ST_DECODE: begin
        w_alu_src_b = c_alu_b_imm_sh2;
        if (opcode == c_op_j) begin
          w_pc_en      = 1'b1;
          w_pc_src     = c_pc_src_jump;
          w_instr_done = 1'b1;
          w_next_state = ST_FETCH;
        end else if (!is_supported(opcode)) begin
          w_illegal_op = 1'b1;
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        w_alu_src_a = 1'b1;
        case (r_opcode)
          c_op_rtype: begin
            w_alu_src_b  = c_alu_b_rt;
            w_alu_op     = c_alu_op_funct;
            w_next_state = ST_WB;
          end
          c_op_lw, c_op_sw: begin
            w_alu_src_b  = c_alu_b_imm;
            w_next_state = ST_MEM;
          end
          c_op_addi: begin
            w_alu_src_b  = c_alu_b_imm;
            w_next_state = ST_WB;
          end
          c_op_beq: begin
            w_alu_src_b  = c_alu_b_rt;
            w_alu_op     = c_alu_op_sub;
            w_pc_src     = c_pc_src_branch;
            w_pc_en      = zero;
            w_instr_done = 1'b1;
            w_next_state = ST_FETCH;
          end
          default: w_next_state = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        if (r_opcode == c_op_sw) begin
          w_mem_write = 1'b1;
          if (mem_ready) begin
            w_instr_done = 1'b1;
            w_next_state = ST_FETCH;
          end
        end else begin
          w_mem_read = 1'b1;
          if (mem_ready) begin
            w_next_state = ST_WB;
          end
        end
      end

      ST_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dest   = (r_opcode == c_op_rtype);
        w_mem_to_reg = (r_opcode == c_op_lw);
        w_instr_done = 1'b1;
        w_next_state = ST_FETCH;
      end

      default: w_next_state = ST_FETCH;
    endcase
  end

  // Strobes are forced low during reset and the first post-reset cycle
  assign pc_en      = w_pc_en      & w_out_en;
  assign pc_src     = w_out_en ? w_pc_src    : 2'b00;
  assign ir_write   = w_ir_write   & w_out_en;
  assign mem_read   = w_mem_read   & w_out_en;
  assign mem_write  = w_mem_write  & w_out_en;
  assign reg_write  = w_reg_write  & w_out_en;
  assign reg_dest   = w_reg_dest   & w_out_en;
  assign mem_to_reg = w_mem_to_reg & w_out_en;
  assign alu_src_a  = w_alu_src_a  & w_out_en;
  assign alu_src_b  = w_out_en ? w_alu_src_b : 2'b00;
  assign alu_op     = w_out_en ? w_alu_op    : 2'b00;
  assign instr_done = w_instr_done & w_out_en;
  assign illegal_op = w_illegal_op & w_out_en;
  assign state      = r_state;

  retire_counter #(
    .WIDTH (16)
  ) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (instr_done),
    .count (instr_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed self-checking bench for multicycle_control.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_en, ir_write, mem_read, mem_write, reg_write, reg_dest;
  logic        mem_to_reg, alu_src_a, instr_done, illegal_op;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [2:0]  state;
  logic [15:0] instr_count;

  typedef struct {
    logic [2:0]  st;
    logic [15:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  logic [15:0] F_WAIT, F_GO, DEC, DEC_J, DEC_ILL, EX_R, EX_MI, EX_BEQ_T, EX_BEQ_NT;
  logic [15:0] MEM_LW, MEM_SW, MEM_SW_RDY, WB_LW, WB_R, WB_ADDI;

  multicycle_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .ir_write    (ir_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .reg_dest    (reg_dest),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .state       (state),
    .instr_count (instr_count)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Expected control word, packed in the same order the bench samples ports
  function automatic logic [15:0] cv(input logic pe, input logic [1:0] ps,
                                     input logic irw, input logic mr, input logic mw,
                                     input logic rw, input logic rd, input logic m2r,
                                     input logic a, input logic [1:0] b,
                                     input logic [1:0] op, input logic dn,
                                     input logic il);
    return {pe, ps, irw, mr, mw, rw, rd, m2r, a, b, op, dn, il};
  endfunction

  // One cycle: drive inputs at the falling edge, queue the expectation,
  // then sample 1 ns later and compare against the popped entry
  task automatic step(input string tag, input logic r, input logic [5:0] op,
                      input logic z, input logic rdy, input logic [2:0] est,
                      input logic [15:0] ectl, input logic [15:0] ecnt);
    exp_t        e;
    exp_t        got;
    logic [15:0] obs;
    @(negedge clk);
    rst_n     = r;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    e.st  = est;
    e.ctl = ectl;
    e.cnt = ecnt;
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    obs = {pc_en, pc_src, ir_write, mem_read, mem_write, reg_write, reg_dest,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done, illegal_op};
    total++;
    assert (state === got.st) else begin
      bad++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state, got.st);
    end
    total++;
    assert (obs === got.ctl) else begin
      bad++;
      $error("FAIL %s ctl observed=%h expected=%h", tag, obs, got.ctl);
    end
    total++;
    assert (instr_count === got.cnt) else begin
      bad++;
      $error("FAIL %s instr_count observed=%h expected=%h", tag, instr_count, got.cnt);
    end
  endtask

  initial begin
    //              pe ps    irw mr mw rw rd m2r a  b      op     dn il
    F_WAIT     = cv(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    F_GO       = cv(1, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    DEC        = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0);
    DEC_J      = cv(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 1, 0);
    DEC_ILL    = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 1);
    EX_R       = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0);
    EX_MI      = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0);
    EX_BEQ_T   = cv(1, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1, 0);
    EX_BEQ_NT  = cv(0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1, 0);
    MEM_LW     = cv(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    MEM_SW     = cv(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    MEM_SW_RDY = cv(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    WB_LW      = cv(0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 1, 0);
    WB_R       = cv(0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0);
    WB_ADDI    = cv(0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0);

    repeat (2) @(posedge clk);

    // Reset: strobes quiet, even with mem_ready high in FETCH
    step("rst_hold",    0, OP_LW, 0, 1, 3'd0, 16'h0000, 16'd0);
    step("rst_release", 1, OP_LW, 0, 1, 3'd0, 16'h0000, 16'd0);

    // lw, ready every cycle; opcode port scrambled after decode
    step("lw_fetch",  1, OP_LW,  0, 1, 3'd0, F_GO,   16'd0);
    step("lw_decode", 1, OP_LW,  0, 1, 3'd1, DEC,    16'd0);
    step("lw_exec",   1, OP_BAD, 0, 1, 3'd2, EX_MI,  16'd0);
    step("lw_mem",    1, OP_BAD, 0, 1, 3'd3, MEM_LW, 16'd0);
    step("lw_wb",     1, OP_BAD, 0, 1, 3'd4, WB_LW,  16'd0);
    step("lw_done",   1, OP_SW,  0, 0, 3'd0, F_WAIT, 16'd1);

    // sw with three wait cycles in MEM
    step("sw_fetch",  1, OP_SW, 0, 1, 3'd0, F_GO,  16'd1);
    step("sw_decode", 1, OP_SW, 0, 1, 3'd1, DEC,   16'd1);
    step("sw_exec",   1, OP_SW, 0, 1, 3'd2, EX_MI, 16'd1);
    for (int i = 0; i < 3; i++) begin
      step("sw_mem_wait", 1, OP_SW, 0, 0, 3'd3, MEM_SW, 16'd1);
    end
    step("sw_mem_ready", 1, OP_SW,  0, 1, 3'd3, MEM_SW_RDY, 16'd1);
    step("sw_done",      1, OP_BEQ, 0, 0, 3'd0, F_WAIT,     16'd2);

    // beq taken then not taken
    step("beq1_fetch",  1, OP_BEQ, 0, 1, 3'd0, F_GO,      16'd2);
    step("beq1_decode", 1, OP_BEQ, 0, 1, 3'd1, DEC,       16'd2);
    step("beq1_exec",   1, OP_BEQ, 1, 1, 3'd2, EX_BEQ_T,  16'd2);
    step("beq2_fetch",  1, OP_BEQ, 0, 1, 3'd0, F_GO,      16'd3);
    step("beq2_decode", 1, OP_BEQ, 0, 1, 3'd1, DEC,       16'd3);
    step("beq2_exec",   1, OP_BEQ, 0, 1, 3'd2, EX_BEQ_NT, 16'd3);

    // Unsupported opcode: pulse, back to FETCH, no retire
    step("ill_fetch",  1, OP_BAD, 0, 1, 3'd0, F_GO,    16'd4);
    step("ill_decode", 1, OP_BAD, 0, 1, 3'd1, DEC_ILL, 16'd4);
    step("ill_after",  1, OP_BAD, 0, 0, 3'd0, F_WAIT,  16'd4);

    // addi
    step("addi_fetch",  1, OP_ADDI, 0, 1, 3'd0, F_GO,    16'd4);
    step("addi_decode", 1, OP_ADDI, 0, 1, 3'd1, DEC,     16'd4);
    step("addi_exec",   1, OP_ADDI, 0, 1, 3'd2, EX_MI,   16'd4);
    step("addi_wb",     1, OP_ADDI, 0, 1, 3'd4, WB_ADDI, 16'd4);

    // A run of jumps
    for (int i = 0; i < 8; i++) begin
      step("j_fetch",  1, OP_J, 0, 1, 3'd0, F_GO,  16'(5 + i));
      step("j_decode", 1, OP_J, 0, 1, 3'd1, DEC_J, 16'(5 + i));
    end
    step("j_run_done", 1, OP_J, 0, 0, 3'd0, F_WAIT, 16'd13);

    // Jump the counter close to its limit while FETCH is stalled
    @(negedge clk);
    mem_ready = 1'b0;
    force dut.u_retire_counter.r_count = 16'hFFFE;
    @(negedge clk);
    release dut.u_retire_counter.r_count;

    step("wrap_j_fetch",  1, OP_J, 0, 1, 3'd0, F_GO,  16'hFFFE);
    step("wrap_j_decode", 1, OP_J, 0, 1, 3'd1, DEC_J, 16'hFFFE);
    step("r_fetch",       1, OP_R, 0, 1, 3'd0, F_GO,  16'hFFFF);
    step("r_decode",      1, OP_R, 0, 1, 3'd1, DEC,   16'hFFFF);
    step("r_exec",        1, OP_R, 0, 1, 3'd2, EX_R,  16'hFFFF);
    step("r_wb",          1, OP_R, 0, 1, 3'd4, WB_R,  16'hFFFF);
    step("r_wrapped",     1, OP_R, 0, 0, 3'd0, F_WAIT, 16'h0000);

    // Reset during a MEM wait aborts the load without a retire pulse
    step("a_fetch",   1, OP_ADDI, 0, 1, 3'd0, F_GO,    16'd0);
    step("a_decode",  1, OP_ADDI, 0, 1, 3'd1, DEC,     16'd0);
    step("a_exec",    1, OP_ADDI, 0, 1, 3'd2, EX_MI,   16'd0);
    step("a_wb",      1, OP_ADDI, 0, 1, 3'd4, WB_ADDI, 16'd0);
    step("lw2_fetch", 1, OP_LW,   0, 1, 3'd0, F_GO,    16'd1);
    step("lw2_decode",1, OP_LW,   0, 1, 3'd1, DEC,     16'd1);
    step("lw2_exec",  1, OP_LW,   0, 1, 3'd2, EX_MI,   16'd1);
    step("lw2_wait",  1, OP_LW,   0, 0, 3'd3, MEM_LW,  16'd1);
    step("mid_rst",   0, OP_LW,   0, 1, 3'd3, 16'h0000, 16'd1);
    step("rst_fetch", 0, OP_LW,   0, 1, 3'd0, 16'h0000, 16'd0);
    step("rel2",      1, OP_LW,   0, 1, 3'd0, 16'h0000, 16'd0);
    step("post_rst",  1, OP_LW,   0, 1, 3'd0, F_GO,     16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL be clocked by one clock; reset SHALL be synchronous and active-low.
REQ-002 Port `clk`, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port `rst_n`, input, 1 bit: synchronous active-low reset.
REQ-004 Port `opcode`, input, 6 bits: instruction[31:26] from the instruction register.
REQ-005 Port `zero`, input, 1 bit: ALU zero flag from execute.
REQ-006 Port `mem_ready`, input, 1 bit: memory access complete this cycle.
REQ-007 Port `pc_en`, output, 1 bit: PC load enable.
REQ-008 Port `pc_src`, output, 2 bits: PC source select.
- 00 = PC+4
- 01 = branch target
- 10 = jump target
REQ-009 Port `ir_write`, output, 1 bit: instruction register load.
REQ-010 Port `mem_read`, output, 1 bit: memory read strobe.
REQ-011 Port `mem_write`, output, 1 bit: memory write strobe.
REQ-012 Port `reg_write`, output, 1 bit: register file write enable.
REQ-013 Port `reg_dest`, output, 1 bit: write-register select; 1 = rd, 0 = rt.
REQ-014 Port `mem_to_reg`, output, 1 bit: writeback select; 1 = memory data, 0 = ALU result.
REQ-015 Port `alu_src_a`, output, 1 bit: ALU A select; 0 = PC, 1 = rs.
REQ-016 Port `alu_src_b`, output, 2 bits: ALU B select.
- 00 = rt
- 01 = constant 4
- 10 = sign-extended immediate
- 11 = sign-extended immediate << 2
REQ-017 Port `alu_op`, output, 2 bits: ALU operation class.
- 00 = add
- 01 = subtract
- 10 = decode funct
REQ-018 Port `instr_done`, output, 1 bit: one-cycle pulse when an instruction retires.
REQ-019 Port `illegal_op`, output, 1 bit: one-cycle pulse when an unsupported opcode is decoded.
REQ-020 Port `state`, output, 3 bits: current FSM state, for debug.
REQ-021 Port `instr_count`, output, 16 bits: retired-instruction counter.

Function
REQ-022 The FSM SHALL have five states: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4.
REQ-023 Supported opcodes SHALL be:
- R-type 000000
- lw 100011
- sw 101011
- beq 000100
- j 000010
- addi 001000
REQ-024 Control outputs SHALL be combinational in state, latched opcode, zero and mem_ready; unlisted outputs are 0.
REQ-025 FETCH SHALL assert mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00.
- While mem_ready=0: hold in FETCH.
- When mem_ready=1: additionally assert ir_write=1, pc_en=1, pc_src=00, then go to DECODE.
REQ-026 DECODE SHALL capture opcode into an internal register and assert alu_src_a=0, alu_src_b=11, alu_op=00.
- j: pc_en=1, pc_src=10, instr_done=1, go to FETCH.
- Unsupported opcode: illegal_op=1, go to FETCH, instr_done=0.
- All other supported opcodes: go to EXECUTE.
REQ-027 All states after DECODE SHALL use the latched opcode, not the live port.
REQ-028 EXECUTE, R-type: alu_src_a=1, alu_src_b=00, alu_op=10; go to WB.
REQ-029 EXECUTE, lw/sw/addi: alu_src_a=1, alu_src_b=10, alu_op=00.
- lw/sw: go to MEM.
- addi: go to WB.
REQ-030 EXECUTE, beq: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero, instr_done=1; go to FETCH.
REQ-031 MEM, lw: mem_read=1; hold while mem_ready=0; on mem_ready=1 go to WB.
REQ-032 MEM, sw: mem_write=1; hold while mem_ready=0; on mem_ready=1 assert instr_done=1 and go to FETCH.
REQ-033 WB SHALL assert reg_write=1, reg_dest=1 for R-type only, mem_to_reg=1 for lw only, and instr_done=1; go to FETCH.
REQ-034 instr_count SHALL increment by 1 on each cycle instr_done=1, wrapping from 0xFFFF to 0x0000.
REQ-035 illegal_op SHALL NOT increment instr_count.
REQ-036 mem_ready SHALL be ignored in DECODE, EXECUTE and WB.

Reset
REQ-037 While rst_n=0 at a clock edge, state SHALL become FETCH, instr_count 0, and the latched opcode 000000.
REQ-038 While rst_n=0, every control output SHALL be 0, including mem_read in FETCH.
REQ-039 Reset asserted in any state, including mid-MEM wait, SHALL abort the instruction with no instr_done pulse.
REQ-040 The first FETCH read SHALL occur in the first cycle after rst_n=1 is sampled.

Structure
REQ-041 A shared package SHALL hold:
- the state enum;
- opcode constants;
- pc_src, alu_src_b and alu_op encodings.
REQ-042 The datapath and main_control SHALL import the encodings from that package.
REQ-043 The retire counter SHALL be a sub-module `retire_counter` (enable, synchronous active-low reset, 16-bit wrap).

Verification
REQ-044 Reset then lw, mem_ready=1 every cycle -> state sequence 0,1,2,3,4,0; one instr_done; instr_count=1.
REQ-045 sw with mem_ready low 3 cycles in MEM -> mem_write high 4 cycles; instr_done only on the ready cycle.
REQ-046 beq with zero=1, then beq with zero=0 -> pc_en=1/pc_src=01 in EXECUTE for the first only; instr_count=2.
REQ-047 opcode 111111 -> illegal_op pulse in DECODE; return to FETCH; instr_count unchanged.
REQ-048 instr_count preset to 0xFFFF via 65535 j instructions, then one R-type -> instr_count=0x0000; WB has reg_dest=1, reg_write=1.
REQ-049 rst_n=0 during a MEM wait -> next state FETCH; all outputs 0 during reset; no instr_done.
